// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared constants, FSM encoding and helpers for the UART
//                LED command decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // ASCII characters used by the command framing and replies
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_Q  = 8'h3F;

    // Every reply is exactly three bytes: payload, CR, LF
    localparam int REPLY_LEN = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARG     = 3'd1,
        ST_TERM    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_EXEC    = 3'd4,
        ST_REPLY   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_SET    = 2'd0,
        CMD_TOGGLE = 2'd1,
        CMD_QUERY  = 2'd2
    } cmd_t;

    // Fold lowercase letters to uppercase so command letters are case-insensitive
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : hex_ascii
//  Description : Combinational ASCII hex digit decoder (either case) and
//                nibble to uppercase ASCII encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_ascii (
    input  logic [7:0] ascii,
    output logic [3:0] dec_nibble,
    output logic       dec_valid,
    input  logic [3:0] nibble,
    output logic [7:0] enc_ascii
);

    // Decode '0'-'9', 'A'-'F', 'a'-'f' into a nibble plus a valid flag
    always_comb begin
        dec_nibble = 4'h0;
        dec_valid  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            dec_nibble = ascii[3:0];
            dec_valid  = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            // 'A' / 'a' have low nibble 1, so adding 9 yields 10..15
            dec_nibble = ascii[3:0] + 4'd9;
            dec_valid  = 1'b1;
        end
    end

    // Encode a nibble as an uppercase hex character
    always_comb begin
        if (nibble < 4'd10) begin
            enc_ascii = 8'h30 + {4'h0, nibble};
        end else begin
            enc_ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_led_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : uart_led_cmd
//  Description : CR-terminated ASCII command decoder driving the LED nibble
//                and replying through the UART transmitter (K / E / status).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_led_cmd
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic [3:0] led,
    output logic       err
);

    localparam int             TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     IDX_LAST = 2'(REPLY_LEN - 1);

    state_t         r_state;
    cmd_t           r_cmd;
    logic [3:0]     r_arg;
    logic           r_bad;
    logic [TW-1:0]  r_tcnt;
    logic [23:0]    r_reply;
    logic [1:0]     r_idx;

    logic [7:0]     w_byte_up;
    logic [3:0]     w_dec_nibble;
    logic           w_dec_valid;
    logic [7:0]     w_led_ascii;
    logic           w_arg_ok;
    logic           w_in_wait;
    logic           w_timeout;
    logic [1:0]     w_bit;
    logic [3:0]     w_toggle_mask;
    logic [7:0]     w_reply_byte;

    hex_ascii u_hex (
        .ascii      (rx_data),
        .dec_nibble (w_dec_nibble),
        .dec_valid  (w_dec_valid),
        .nibble     (led),
        .enc_ascii  (w_led_ascii)
    );

    assign w_byte_up = to_upper(rx_data);

    // Argument acceptance: any hex digit for S, only '1'..'4' for T
    always_comb begin
        w_arg_ok = 1'b0;
        if (r_cmd == CMD_SET) begin
            w_arg_ok = w_dec_valid;
        end else begin
            w_arg_ok = (rx_data >= 8'h31) && (rx_data <= 8'h34);
        end
    end

    // Timeout applies only while a command is partially received; a byte wins
    assign w_in_wait = (r_state == ST_ARG) || (r_state == ST_TERM) ||
                       (r_state == ST_DISCARD);
    assign w_timeout = w_in_wait && !rx_valid && (r_tcnt == T_LAST);

    // T argument 1..4 maps to bit 0..3 (4 wraps to 0 in two bits, minus 1 gives 3)
    assign w_bit         = r_arg[1:0] - 2'd1;
    assign w_toggle_mask = 4'b0001 << w_bit;

    // Select the reply byte addressed by the send index
    always_comb begin
        case (r_idx)
            2'd0:    w_reply_byte = r_reply[23:16];
            2'd1:    w_reply_byte = r_reply[15:8];
            default: w_reply_byte = r_reply[7:0];
        endcase
    end

    // Command FSM with registered LED, reply and strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_SET;
            r_arg   <= 4'h0;
            r_bad   <= 1'b0;
            r_tcnt  <= '0;
            r_reply <= 24'h0;
            r_idx   <= 2'd0;
            led     <= 4'h0;
            tx_send <= 1'b0;
            tx_data <= 8'h00;
            err     <= 1'b0;
        end else begin
            err     <= 1'b0;
            tx_send <= 1'b0;

            if (!w_in_wait || rx_valid || w_timeout) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
                            r_state <= ST_IDLE;
                        end else if (w_byte_up == ASCII_S) begin
                            r_cmd   <= CMD_SET;
                            r_state <= ST_ARG;
                        end else if (w_byte_up == ASCII_T) begin
                            r_cmd   <= CMD_TOGGLE;
                            r_state <= ST_ARG;
                        end else if (rx_data == ASCII_Q) begin
                            r_cmd   <= CMD_QUERY;
                            r_state <= ST_TERM;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end
                end

                ST_ARG: begin
                    if (rx_valid) begin
                        if (rx_data == ASCII_CR) begin
                            r_bad   <= 1'b1;
                            err     <= 1'b1;
                            r_state <= ST_EXEC;
                        end else if (w_arg_ok) begin
                            r_arg   <= w_dec_nibble;
                            r_state <= ST_TERM;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_TERM: begin
                    if (rx_valid) begin
                        if (rx_data == ASCII_CR) begin
                            r_bad   <= 1'b0;
                            r_state <= ST_EXEC;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_DISCARD: begin
                    if (rx_valid) begin
                        if (rx_data == ASCII_CR) begin
                            r_bad   <= 1'b1;
                            err     <= 1'b1;
                            r_state <= ST_EXEC;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_EXEC: begin
                    if (r_bad) begin
                        r_reply <= {ASCII_E, ASCII_CR, ASCII_LF};
                    end else begin
                        case (r_cmd)
                            CMD_SET: begin
                                led     <= r_arg;
                                r_reply <= {ASCII_K, ASCII_CR, ASCII_LF};
                            end
                            CMD_TOGGLE: begin
                                led     <= led ^ w_toggle_mask;
                                r_reply <= {ASCII_K, ASCII_CR, ASCII_LF};
                            end
                            default: begin
                                r_reply <= {w_led_ascii, ASCII_CR, ASCII_LF};
                            end
                        endcase
                    end
                    r_idx   <= 2'd0;
                    r_state <= ST_REPLY;
                end

                ST_REPLY: begin
                    // Back-to-back strobes are blocked so the UART has a cycle to drop ready
                    if (tx_ready && !tx_send) begin
                        tx_send <= 1'b1;
                        tx_data <= w_reply_byte;
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= 2'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_led_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_led_cmd
//  Description : Self-checking bench for uart_led_cmd: vector table of
//                commands plus timing, timeout, back-pressure and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_led_cmd;

    localparam int T = 20;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [3:0] led;
    logic       err;

    uart_led_cmd #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .led      (led),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bytes;   // first byte in [31:24]
        int          n;
        logic [3:0]  led;
        logic [23:0] reply;
        int          errs;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        stall   = 1'b0;

    // Monitor state (written only by the monitor process)
    logic [7:0]  tx_log [0:255];
    int          tx_total   = 0;
    int          err_total  = 0;
    int          wide_cnt   = 0;
    int          stall_sends = 0;
    logic        prev_send  = 1'b0;

    // Sample DUT outputs on the falling edge
    always @(negedge clk) begin
        if (tx_send) begin
            tx_log[tx_total[7:0]] <= tx_data;
            tx_total <= tx_total + 1;
            if (prev_send) wide_cnt <= wide_cnt + 1;
            if (stall) stall_sends <= stall_sends + 1;
        end
        if (err) err_total <= err_total + 1;
        prev_send <= tx_send;
    end

    // Simple transmitter model: busy for a few cycles after each send
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall) begin
                tx_ready = 1'b0;
            end else if (tx_send) begin
                tx_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                tx_ready = !stall;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Wait for a 3-byte reply starting at log index base and check it
    task automatic expect_reply(input string name, input int base, input logic [23:0] exp);
        for (int k = 0; k < 400 && tx_total < base + 3; k++) @(negedge clk);
        repeat (12) @(negedge clk);
        chk({name, " reply count"}, 32'(tx_total - base), 32'd3);
        chk({name, " byte0"}, {24'h0, tx_log[8'(base)]},     {24'h0, exp[23:16]});
        chk({name, " byte1"}, {24'h0, tx_log[8'(base + 1)]}, {24'h0, exp[15:8]});
        chk({name, " byte2"}, {24'h0, tx_log[8'(base + 2)]}, {24'h0, exp[7:0]});
    endtask

    function automatic vec_t mk(input logic [31:0] b, input int n, input logic [3:0] l,
                                input logic [23:0] r, input int e);
        vec_t v;
        v.bytes = b; v.n = n; v.led = l; v.reply = r; v.errs = e;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        int base;
        int ebase;
        logic [31:0] bv;

        // Starting LED value is 3 after the hand-written timing sequence
        vecs[0]  = mk(32'h53410D00, 3, 4'hA, 24'h4B0D0A, 0); // SA
        vecs[1]  = mk(32'h54310D00, 3, 4'hB, 24'h4B0D0A, 0); // T1
        vecs[2]  = mk(32'h3F0D0000, 2, 4'hB, 24'h420D0A, 0); // ?
        vecs[3]  = mk(32'h54350D00, 3, 4'hB, 24'h450D0A, 1); // T5
        vecs[4]  = mk(32'h580D0000, 2, 4'hB, 24'h450D0A, 1); // X
        vecs[5]  = mk(32'h73350D00, 3, 4'h5, 24'h4B0D0A, 0); // s5
        vecs[6]  = mk(32'h74340D00, 3, 4'hD, 24'h4B0D0A, 0); // t4
        vecs[7]  = mk(32'h3F0D0000, 2, 4'hD, 24'h440D0A, 0); // ?
        vecs[8]  = mk(32'h53470D00, 3, 4'hD, 24'h450D0A, 1); // SG
        vecs[9]  = mk(32'h530D0000, 2, 4'hD, 24'h450D0A, 1); // S CR
        vecs[10] = mk(32'h5331320D, 4, 4'hD, 24'h450D0A, 1); // S12
        vecs[11] = mk(32'h0A3F0D00, 3, 4'hD, 24'h440D0A, 0); // LF ?
        vecs[12] = mk(32'h73660D00, 3, 4'hF, 24'h4B0D0A, 0); // sf
        vecs[13] = mk(32'h54320D00, 3, 4'hD, 24'h4B0D0A, 0); // T2
        vecs[14] = mk(32'h54300D00, 3, 4'hD, 24'h450D0A, 1); // T0

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset led",     {28'h0, led},     32'h0);
        chk("reset tx_send", {31'h0, tx_send}, 32'h0);
        chk("reset tx_data", {24'h0, tx_data}, 32'h0);
        chk("reset err",     {31'h0, err},     32'h0);

        // LED update timing: unchanged during EXEC, new value one cycle later
        base = tx_total; ebase = err_total;
        send_byte(8'h53);
        send_byte(8'h33);
        @(posedge clk); #1; rx_valid = 1'b1; rx_data = 8'h0D;
        @(posedge clk); #1; rx_valid = 1'b0;
        chk("S3 exec led",     {28'h0, led},     32'h0);
        chk("S3 exec err",     {31'h0, err},     32'h0);
        chk("S3 exec tx_send", {31'h0, tx_send}, 32'h0);
        @(posedge clk); #1;
        chk("S3 led after exec", {28'h0, led}, 32'h3);
        expect_reply("S3", base, 24'h4B0D0A);
        chk("S3 err count", 32'(err_total - ebase), 32'd0);

        // Error pulse is high in the EXEC cycle and only then
        base = tx_total; ebase = err_total;
        send_byte(8'h58);
        @(posedge clk); #1; rx_valid = 1'b1; rx_data = 8'h0D;
        @(posedge clk); #1; rx_valid = 1'b0;
        chk("X exec err", {31'h0, err}, 32'h1);
        @(posedge clk); #1;
        chk("X err after exec", {31'h0, err}, 32'h0);
        expect_reply("X", base, 24'h450D0A);
        chk("X led", {28'h0, led}, 32'h3);

        // Command table
        for (int i = 0; i < 15; i++) begin
            base = tx_total; ebase = err_total;
            bv = vecs[i].bytes;
            for (int j = 0; j < vecs[i].n; j++) begin
                send_byte(bv[31:24]);
                bv = bv << 8;
            end
            expect_reply($sformatf("vec%0d", i), base, vecs[i].reply);
            chk($sformatf("vec%0d led", i), {28'h0, led}, {28'h0, vecs[i].led});
            chk($sformatf("vec%0d err", i), 32'(err_total - ebase), 32'(vecs[i].errs));
        end

        // Argument arriving exactly on the timeout cycle is still accepted
        base = tx_total;
        send_byte(8'h53);
        repeat (T - 2) @(posedge clk);
        send_byte(8'h37);
        send_byte(8'h0D);
        expect_reply("byte wins", base, 24'h4B0D0A);
        chk("byte wins led", {28'h0, led}, 32'h7);

        // One cycle later the partial command is abandoned silently
        base = tx_total; ebase = err_total;
        send_byte(8'h53);
        repeat (T - 1) @(posedge clk);
        repeat (5) @(negedge clk);
        chk("timeout no reply", 32'(tx_total - base), 32'd0);
        chk("timeout no err",   32'(err_total - ebase), 32'd0);
        send_byte(8'h3F);
        send_byte(8'h0D);
        expect_reply("after timeout", base, 24'h370D0A);
        chk("after timeout led", {28'h0, led}, 32'h7);

        // Back-pressure: transmitter busy for 50 cycles
        base = tx_total;
        stall = 1'b1;
        send_byte(8'h3F);
        send_byte(8'h0D);
        repeat (50) @(negedge clk);
        chk("stall no send", 32'(tx_total - base), 32'd0);
        @(posedge clk); #1;
        stall = 1'b0;
        expect_reply("stall", base, 24'h370D0A);
        chk("stall sends while low", 32'(stall_sends), 32'd0);
        chk("strobe width", 32'(wide_cnt), 32'd0);

        // Reset after the first reply byte aborts the rest
        base = tx_total;
        send_byte(8'h3F);
        send_byte(8'h0D);
        for (int k = 0; k < 100 && tx_total < base + 1; k++) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset aborts reply", 32'(tx_total - base), 32'd1);
        chk("reset led cleared",  {28'h0, led}, 32'h0);
        base = tx_total;
        send_byte(8'h3F);
        send_byte(8'h0D);
        expect_reply("post reset status", base, 24'h300D0A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
